wb_stage: RTL



---
 rtl/y86_pkg.sv | 56 +++++
 rtl/wb_dst_decode.sv | 38 +++
 rtl/wb_stage.sv | 118 +++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
//------------------------------------------------------------------------------
// y86_pkg : shared Y86-64 pipeline constants and W-register control type
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } wb_state_t;

  // Control half of the W register; the wide data fields live beside it.
  typedef struct packed {
    logic [2:0] stat;
    logic [3:0] icode;
    logic       cnd;
    logic [3:0] ra;
    logic [3:0] rb;
    logic       valid;
  } w_ctrl_t;

  localparam w_ctrl_t W_BUBBLE = '{
    stat:  SAOK,
    icode: INOP,
    cnd:   1'b0,
    ra:    RNONE,
    rb:    RNONE,
    valid: 1'b0
  };

endpackage : y86_pkg

`default_nettype wire

// File: rtl/wb_dst_decode.sv
//------------------------------------------------------------------------------
// wb_dst_decode : register-file destination IDs from icode/cnd/rA/rB
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_dst_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic       cnd,
  input  logic [3:0] ra,
  input  logic [3:0] rb,
  output logic [3:0] dst_e,
  output logic [3:0] dst_m
);

  always_comb begin
    dst_e = RNONE;
    case (icode)
      IIRMOVQ, IOPQ:                 dst_e = rb;
      IRRMOVQ:                       dst_e = cnd ? rb : RNONE;
      ICALL, IRET, IPUSHQ, IPOPQ:    dst_e = RRSP;
      default:                       dst_e = RNONE;
    endcase
  end

  always_comb begin
    dst_m = RNONE;
    case (icode)
      IMRMOVQ, IPOPQ: dst_m = ra;
      default:        dst_m = RNONE;
    endcase
  end

endmodule : wb_dst_decode

`default_nettype wire

// File: rtl/wb_stage.sv
//------------------------------------------------------------------------------
// wb_stage : Y86-64 write-back stage (W register, RF write ports, status,
//            retired-instruction counter)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_stage
  import y86_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int REG_W    = 4,
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          m_stat,
  input  logic [3:0]          m_icode,
  input  logic                m_cnd,
  input  logic [REG_W-1:0]    m_rA,
  input  logic [REG_W-1:0]    m_rB,
  input  logic [DATA_W-1:0]   m_valE,
  input  logic [DATA_W-1:0]   m_valM,
  input  logic                w_stall,
  input  logic                w_bubble,
  output logic [REG_W-1:0]    rf_dstE,
  output logic [DATA_W-1:0]   rf_valE,
  output logic                rf_weE,
  output logic [REG_W-1:0]    rf_dstM,
  output logic [DATA_W-1:0]   rf_valM,
  output logic                rf_weM,
  output logic [2:0]          w_stat,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  w_ctrl_t             w_ctrl;
  logic [DATA_W-1:0]   w_val_e;
  logic [DATA_W-1:0]   w_val_m;
  wb_state_t           state;
  logic                counted;
  logic [RETIRE_W-1:0] retired_cnt;

  logic [3:0] dst_e;
  logic [3:0] dst_m;
  logic       run_aok;
  logic       freeze;
  logic       count_en;

  wb_dst_decode u_dst_decode (
    .icode (w_ctrl.icode),
    .cnd   (w_ctrl.cnd),
    .ra    (w_ctrl.ra),
    .rb    (w_ctrl.rb),
    .dst_e (dst_e),
    .dst_m (dst_m)
  );

  assign run_aok = (state == RUN) && (w_ctrl.stat == SAOK);

  // A non-AOK instruction in W freezes the register on the same edge the
  // FSM enters HALTED, so w_stat keeps reporting the faulting status.
  assign freeze = (state == HALTED) || (w_ctrl.stat != SAOK);

  // 'counted' keeps a stalled instruction from being retired more than once.
  assign count_en = run_aok && w_ctrl.valid && (w_ctrl.icode != INOP) && !counted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ctrl      <= W_BUBBLE;
      w_val_e     <= '0;
      w_val_m     <= '0;
      state       <= RUN;
      counted     <= 1'b0;
      retired_cnt <= '0;
    end else begin
      if ((state == RUN) && (w_ctrl.stat != SAOK)) begin
        state <= HALTED;
      end

      if (count_en) begin
        counted <= 1'b1;
        if (retired_cnt != {RETIRE_W{1'b1}}) begin
          retired_cnt <= retired_cnt + 1'b1;
        end
      end

      if (!freeze) begin
        if (w_bubble) begin
          w_ctrl  <= W_BUBBLE;
          w_val_e <= '0;
          w_val_m <= '0;
          counted <= 1'b0;
        end else if (!w_stall) begin
          w_ctrl  <= '{stat: m_stat, icode: m_icode, cnd: m_cnd,
                       ra: m_rA, rb: m_rB, valid: 1'b1};
          w_val_e <= m_valE;
          w_val_m <= m_valM;
          counted <= 1'b0;
        end
      end
    end
  end

  // popq %rsp targets the same register on both ports; the loaded value wins.
  assign rf_dstE = dst_e;
  assign rf_dstM = dst_m;
  assign rf_weE  = run_aok && (dst_e != RNONE) && (dst_e != dst_m);
  assign rf_weM  = run_aok && (dst_m != RNONE);
  assign rf_valE = w_val_e;
  assign rf_valM = w_val_m;
  assign w_stat  = w_ctrl.stat;
  assign halted  = (state == HALTED);
  assign retired = retired_cnt;

endmodule : wb_stage

`default_nettype wire
